// File: rtl/retire_trace_pkg.sv
// Shared types and constants for the retire trace unit.
// Optional feature macro TRACE_CYCLE_STAMP_EN adds a cycle stamp to every record.
package retire_trace_pkg;

  localparam int REC_CNT_W = 32;

  localparam logic [3:0] NO_ERROR               = 4'd0;
  localparam logic [3:0] HALTED_ON_MEMORY_ERROR = 4'd1;
  localparam logic [3:0] HALTED_ON_HALT         = 4'd2;
  localparam logic [3:0] HALTED_ON_ILLEGAL      = 4'd3;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } rt_state_e;

  typedef struct packed {
    logic [63:0]          pc;
    logic                 wr_en;
    logic [4:0]           wr_idx;
    logic [63:0]          wr_data;
`ifdef TRACE_CYCLE_STAMP_EN
    logic [REC_CNT_W-1:0] cycle;
`endif
  } retire_rec_t;

endpackage

// File: rtl/retire_trace_unit_trace_fifo.sv
// Multi-push / single-pop circular FIFO of retire records with lane compaction.
// Valid lanes land in consecutive slots; lanes beyond the free space are dropped youngest-first.
module trace_fifo
  import retire_trace_pkg::*;
#(
  parameter int RET_W = 2,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [RET_W-1:0]       push_vld,
  input  retire_rec_t            push_rec [RET_W],
  input  logic                   pop_req,
  output retire_rec_t            head_rec,
  output logic [$clog2(DEPTH):0] occ,
  output logic                   drop
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW:0]   free_slots;
  logic [PW:0]   n_keep;
  logic [PW:0]   rank [RET_W];
  logic [RET_W-1:0] keep;
  logic          pop;
  retire_rec_t   mem [DEPTH];

  assign pop      = pop_req && (occ != '0);
  assign head_rec = mem[head];

  // The same-cycle pop frees a slot the push may already use.
  always_comb begin
    free_slots = (PW+1)'(DEPTH) - occ + (PW+1)'(pop);
    n_keep     = '0;
    keep       = '0;
    drop       = 1'b0;
    for (int i = 0; i < RET_W; i++) begin
      rank[i] = n_keep;
      if (push_vld[i]) begin
        if (n_keep < free_slots) begin
          keep[i] = 1'b1;
          n_keep  = n_keep + (PW+1)'(1);
        end else begin
          drop = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < RET_W; i++) begin
      if (keep[i]) mem[tail + rank[i][PW-1:0]] <= push_rec[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      head <= head + PW'(pop);
      tail <= tail + n_keep[PW-1:0];
      occ  <= occ - (PW+1)'(pop) + n_keep;
    end
  end

endmodule

// File: rtl/retire_trace_unit.sv
// Commit-side trace/perf unit: counters, trace FIFO, orderly halt sequencing.
// TRACE_CYCLE_STAMP_EN adds trc_cycle_o carrying the cycle count at push time.
module retire_trace_unit
  import retire_trace_pkg::*;
#(
  parameter int RET_W      = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [RET_W-1:0]      ret_vld_i,
  input  logic [RET_W-1:0]      ret_wr_en_i,
  input  logic [RET_W-1:0][4:0] ret_wr_idx_i,
  input  logic [RET_W-1:0][63:0] ret_wr_data_i,
  input  logic [RET_W-1:0][63:0] ret_npc_i,
  input  logic [3:0]            core_error_status_i,
  output logic                  ret_stall_o,
  output logic                  trc_vld_o,
  input  logic                  trc_rdy_i,
  output logic [63:0]           trc_pc_o,
  output logic                  trc_wr_en_o,
  output logic [4:0]            trc_wr_idx_o,
  output logic [63:0]           trc_wr_data_o,
`ifdef TRACE_CYCLE_STAMP_EN
  output logic [CNT_W-1:0]      trc_cycle_o,
`endif
  output logic [CNT_W-1:0]      clock_count_o,
  output logic [CNT_W-1:0]      instr_count_o,
  output logic                  overflow_o,
  output logic                  halt_o,
  output logic [3:0]            halt_code_o
);

  localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;
  localparam int NW    = $clog2(RET_W + 1);

  logic [1:0]       state;
  logic             running;
  logic [OCC_W-1:0] occ;
  logic             drop;
  logic [RET_W-1:0] push_vld;
  retire_rec_t      push_rec [RET_W];
  retire_rec_t      head_rec;
  logic [NW-1:0]    n_ret;
  logic [CNT_W:0]   instr_sum;

  assign running     = (state == RUN);
  assign push_vld    = running ? ret_vld_i : '0;
  assign trc_vld_o   = (occ != '0);
  assign ret_stall_o = running && (occ > OCC_W'(FIFO_DEPTH - RET_W));
  assign halt_o      = (state == HALTED);

  assign trc_pc_o      = head_rec.pc;
  assign trc_wr_en_o   = head_rec.wr_en;
  assign trc_wr_idx_o  = head_rec.wr_idx;
  assign trc_wr_data_o = head_rec.wr_data;
`ifdef TRACE_CYCLE_STAMP_EN
  assign trc_cycle_o   = CNT_W'(head_rec.cycle);
`endif

  always_comb begin
    n_ret = '0;
    for (int i = 0; i < RET_W; i++) begin
      n_ret = n_ret + NW'(ret_vld_i[i]);
    end
  end

  // Dropped lanes still count as retired.
  assign instr_sum = {1'b0, instr_count_o} + (CNT_W+1)'(n_ret);

  always_comb begin
    for (int i = 0; i < RET_W; i++) begin
      push_rec[i]         = '0;
      push_rec[i].pc      = ret_npc_i[i] - 64'd4;
      push_rec[i].wr_en   = ret_wr_en_i[i];
      push_rec[i].wr_idx  = ret_wr_idx_i[i];
      push_rec[i].wr_data = ret_wr_data_i[i];
`ifdef TRACE_CYCLE_STAMP_EN
      push_rec[i].cycle   = REC_CNT_W'(clock_count_o);
`endif
    end
  end

  trace_fifo #(
    .RET_W (RET_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld (push_vld),
    .push_rec (push_rec),
    .pop_req  (trc_rdy_i),
    .head_rec (head_rec),
    .occ      (occ),
    .drop     (drop)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RUN;
      clock_count_o <= '0;
      instr_count_o <= '0;
      overflow_o    <= 1'b0;
      halt_code_o   <= NO_ERROR;
    end else begin
      case (state)
        RUN: begin
          if (clock_count_o != '1) clock_count_o <= clock_count_o + CNT_W'(1);
          instr_count_o <= instr_sum[CNT_W] ? '1 : instr_sum[CNT_W-1:0];
          if (drop) overflow_o <= 1'b1;
          if (core_error_status_i != NO_ERROR) begin
            halt_code_o <= core_error_status_i;
            state       <= DRAIN;
          end
        end
        DRAIN: begin
          if (occ == '0) state <= HALTED;
        end
        HALTED: ;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_retire_trace_unit.sv
// Randomized and directed bench for retire_trace_unit against a queue-based reference model.
module tb_retire_trace_unit;

  localparam int RET_W = 2;
  localparam int DEPTH = 8;
  localparam int CNT_W = 8;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [RET_W-1:0]       ret_vld = '0;
  logic [RET_W-1:0]       ret_wr_en = '0;
  logic [RET_W-1:0][4:0]  ret_wr_idx = '0;
  logic [RET_W-1:0][63:0] ret_wr_data = '0;
  logic [RET_W-1:0][63:0] ret_npc = '0;
  logic [3:0]             status = 4'd0;
  logic                   trc_rdy = 1'b0;
  logic                   ret_stall, trc_vld, trc_wr_en, ovf, halt;
  logic [63:0]            trc_pc, trc_wr_data;
  logic [4:0]             trc_wr_idx;
  logic [CNT_W-1:0]       clock_count, instr_count;
  logic [3:0]             halt_code;
`ifdef TRACE_CYCLE_STAMP_EN
  logic [CNT_W-1:0]       trc_cycle;
`endif

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [63:0] pc;
    logic        wr_en;
    logic [4:0]  idx;
    logic [63:0] data;
  } mrec_t;

  mrec_t      m_q [$];
  int         m_clk, m_instr, m_mode;
  bit         m_ovf;
  logic [3:0] m_code;

  retire_trace_unit #(.RET_W(RET_W), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .ret_vld_i           (ret_vld),
    .ret_wr_en_i         (ret_wr_en),
    .ret_wr_idx_i        (ret_wr_idx),
    .ret_wr_data_i       (ret_wr_data),
    .ret_npc_i           (ret_npc),
    .core_error_status_i (status),
    .ret_stall_o         (ret_stall),
    .trc_vld_o           (trc_vld),
    .trc_rdy_i           (trc_rdy),
    .trc_pc_o            (trc_pc),
    .trc_wr_en_o         (trc_wr_en),
    .trc_wr_idx_o        (trc_wr_idx),
    .trc_wr_data_o       (trc_wr_data),
`ifdef TRACE_CYCLE_STAMP_EN
    .trc_cycle_o         (trc_cycle),
`endif
    .clock_count_o       (clock_count),
    .instr_count_o       (instr_count),
    .overflow_o          (ovf),
    .halt_o              (halt),
    .halt_code_o         (halt_code)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model: mode 0 = running, 1 = draining, 2 = halted.
  task automatic model_step();
    mrec_t r;
    if (rst) begin
      m_q.delete();
      m_clk = 0; m_instr = 0; m_mode = 0; m_ovf = 0; m_code = 4'd0;
      return;
    end
    if (m_mode == 0) begin
      if (trc_rdy && m_q.size() > 0) m_q.delete(0);
      for (int l = 0; l < RET_W; l++) begin
        if (ret_vld[l]) begin
          if (m_instr < MAXC) m_instr++;
          if (m_q.size() < DEPTH) begin
            r.pc = ret_npc[l] - 64'd4; r.wr_en = ret_wr_en[l];
            r.idx = ret_wr_idx[l]; r.data = ret_wr_data[l];
            m_q.push_back(r);
          end else m_ovf = 1;
        end
      end
      if (m_clk < MAXC) m_clk++;
      if (status != 4'd0) begin m_code = status; m_mode = 1; end
    end else if (m_mode == 1) begin
      if (m_q.size() == 0) m_mode = 2;
      else if (trc_rdy) m_q.delete(0);
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ret_vld = '0; ret_wr_en = '0; ret_wr_idx = '0; ret_wr_data = '0; ret_npc = '0; status = 4'd0;
  endtask

  task automatic drive_lanes(input logic [RET_W-1:0] vld, input logic [63:0] base);
    ret_vld = vld;
    for (int l = 0; l < RET_W; l++) begin
      ret_npc[l]     = base + 64'(4 * (l + 1));
      ret_wr_en[l]   = 1'($urandom);
      ret_wr_idx[l]  = 5'($urandom);
      ret_wr_data[l] = {$urandom, $urandom};
    end
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if ({clock_count, instr_count} !== '0) $display("FAIL reset_counters: got %h want 0", {clock_count, instr_count}); else passed++;
    total++; if ({trc_vld, ret_stall, ovf, halt, halt_code} !== 8'h00) $display("FAIL reset_status: got %b want 0", {trc_vld, ret_stall, ovf, halt, halt_code}); else passed++;
    trc_rdy = 1'b1;
    repeat (5) step();
    total++; if (clock_count !== 8'd5) $display("FAIL idle_clock: got %0d want 5", clock_count); else passed++;
    total++; if ({instr_count, trc_vld, ovf, halt} !== '0) $display("FAIL idle_status: got %h want 0", {instr_count, trc_vld, ovf, halt}); else passed++;
  endtask

  task automatic test_dual_retire();
    apply_reset();
    trc_rdy = 1'b1;
    ret_vld = 2'b11; ret_npc[0] = 64'h104; ret_npc[1] = 64'h108;
    ret_wr_en = 2'b10; ret_wr_idx[1] = 5'd3; ret_wr_data[1] = 64'hAB;
    step();
    idle_inputs();
    total++; if (instr_count !== 8'd2) $display("FAIL dual_instr: got %0d want 2", instr_count); else passed++;
    total++; if ({trc_vld, trc_pc, trc_wr_en} !== {1'b1, 64'h100, 1'b0}) $display("FAIL dual_rec0: got vld=%b pc=%h en=%b want 1/100/0", trc_vld, trc_pc, trc_wr_en); else passed++;
    step();
    total++; if ({trc_vld, trc_pc, trc_wr_en, trc_wr_idx, trc_wr_data} !== {1'b1, 64'h104, 1'b1, 5'd3, 64'hAB})
      $display("FAIL dual_rec1: got vld=%b pc=%h en=%b idx=%0d data=%h want 1/104/1/3/ab", trc_vld, trc_pc, trc_wr_en, trc_wr_idx, trc_wr_data); else passed++;
    step();
    total++; if (trc_vld !== 1'b0) $display("FAIL dual_empty: got %b want 0", trc_vld); else passed++;
  endtask

  task automatic test_single_lane();
    logic [63:0] d;
    apply_reset();
    trc_rdy = 1'b1;
    d = {$urandom, $urandom};
    ret_vld = 2'b10; ret_npc[0] = 64'h5555; ret_npc[1] = 64'h208;
    ret_wr_en = 2'b11; ret_wr_idx[0] = 5'd9; ret_wr_idx[1] = 5'd7; ret_wr_data[1] = d;
    step();
    idle_inputs();
    total++; if (instr_count !== 8'd1) $display("FAIL lane1_instr: got %0d want 1", instr_count); else passed++;
    total++; if ({trc_pc, trc_wr_idx, trc_wr_data} !== {64'h204, 5'd7, d}) $display("FAIL lane1_rec: got pc=%h idx=%0d data=%h want 204/7/%h", trc_pc, trc_wr_idx, trc_wr_data, d); else passed++;
    step();
    total++; if (trc_vld !== 1'b0) $display("FAIL lane1_single: got vld=%b want 0", trc_vld); else passed++;
  endtask

  task automatic test_overflow();
    int n;
    logic [63:0] last_pc;
    apply_reset();
    trc_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin drive_lanes(2'b11, 64'(k * 16)); step(); end
    total++; if (ret_stall !== 1'b0) $display("FAIL stall_at6: got %b want 0", ret_stall); else passed++;
    drive_lanes(2'b01, 64'h700); step();
    total++; if (ret_stall !== 1'b1) $display("FAIL stall_at7: got %b want 1", ret_stall); else passed++;
    drive_lanes(2'b11, 64'h800); step();
    idle_inputs();
    total++; if ({ovf, instr_count} !== {1'b1, 8'd9}) $display("FAIL ovf_set: got ovf=%b instr=%0d want 1/9", ovf, instr_count); else passed++;
    trc_rdy = 1'b1;
    n = 0; last_pc = '0;
    while (trc_vld && n < 20) begin last_pc = trc_pc; step(); n++; end
    total++; if ({n, last_pc} !== {32'd8, 64'h800}) $display("FAIL ovf_drain: got n=%0d last=%h want 8/800", n, last_pc); else passed++;
    total++; if (ovf !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", ovf); else passed++;
  endtask

  task automatic test_full_pop_push();
    int n;
    logic [63:0] last_pc;
    apply_reset();
    trc_rdy = 1'b0;
    for (int k = 0; k < 4; k++) begin drive_lanes(2'b11, 64'(k * 16)); step(); end
    total++; if ({ret_stall, ovf} !== 2'b10) $display("FAIL full_state: got stall/ovf=%b want 10", {ret_stall, ovf}); else passed++;
    trc_rdy = 1'b1;
    drive_lanes(2'b01, 64'h900); step();
    idle_inputs();
    total++; if ({ret_stall, ovf} !== 2'b10) $display("FAIL full_pushpop: got stall/ovf=%b want 10", {ret_stall, ovf}); else passed++;
    n = 0; last_pc = '0;
    while (trc_vld && n < 20) begin last_pc = trc_pc; step(); n++; end
    total++; if ({n, last_pc} !== {32'd8, 64'h900}) $display("FAIL full_drain: got n=%0d last=%h want 8/900", n, last_pc); else passed++;
  endtask

  task automatic test_halt();
    int pops, n;
    apply_reset();
    trc_rdy = 1'b0;
    drive_lanes(2'b11, 64'h300); step();
    drive_lanes(2'b01, 64'h310); step();
    trc_rdy = 1'b1;
    status = 4'd2;
    drive_lanes(2'b01, 64'h400); step();
    total++; if ({clock_count, instr_count, halt} !== {8'd3, 8'd4, 1'b0}) $display("FAIL halt_entry: got clk=%0d instr=%0d halt=%b want 3/4/0", clock_count, instr_count, halt); else passed++;
    pops = 1;
    drive_lanes(2'b11, 64'h500);
    n = 0;
    while (!halt && n < 20) begin if (trc_vld) pops++; step(); n++; end
    total++; if ({halt, pops} !== {1'b1, 32'd4}) $display("FAIL halt_pops: got halt=%b pops=%0d want 1/4", halt, pops); else passed++;
    total++; if ({halt_code, clock_count, instr_count, trc_vld, ret_stall} !== {4'd2, 8'd3, 8'd4, 2'b00})
      $display("FAIL halt_state: got code=%0d clk=%0d instr=%0d vld=%b stall=%b want 2/3/4/0/0", halt_code, clock_count, instr_count, trc_vld, ret_stall); else passed++;
    repeat (3) step();
    total++; if ({halt, clock_count, instr_count, trc_vld} !== {1'b1, 8'd3, 8'd4, 1'b0}) $display("FAIL halt_hold: got halt=%b clk=%0d instr=%0d vld=%b", halt, clock_count, instr_count, trc_vld); else passed++;
    idle_inputs();
  endtask

  task automatic test_reset_in_drain();
    apply_reset();
    trc_rdy = 1'b0;
    for (int k = 0; k < 4; k++) begin drive_lanes(2'b11, 64'(k * 16)); step(); end
    idle_inputs();
    status = 4'd3;
    step();
    step();
    total++; if ({halt, trc_vld, ret_stall, halt_code} !== {3'b010, 4'd3}) $display("FAIL drain_state: got halt/vld/stall=%b code=%0d want 010/3", {halt, trc_vld, ret_stall}, halt_code); else passed++;
    rst = 1'b1; step(); rst = 1'b0;
    status = 4'd0;
    total++; if ({clock_count, instr_count, trc_vld, ret_stall, ovf, halt, halt_code} !== '0) $display("FAIL drain_reset: got %h want 0", {clock_count, instr_count, trc_vld, ret_stall, ovf, halt, halt_code}); else passed++;
    drive_lanes(2'b01, 64'hA00); step();
    idle_inputs();
    total++; if ({clock_count, instr_count, trc_vld, trc_pc} !== {8'd1, 8'd1, 1'b1, 64'hA00}) $display("FAIL drain_rerun: got clk=%0d instr=%0d vld=%b pc=%h want 1/1/1/a00", clock_count, instr_count, trc_vld, trc_pc); else passed++;
  endtask

  task automatic test_random();
    logic [2*CNT_W+7:0] exp_st, got_st;
    apply_reset();
    for (int c = 0; c < 340; c++) begin
      drive_lanes((c < 200) ? RET_W'($urandom) : '1, 64'({$urandom, $urandom}));
      trc_rdy = ($urandom_range(0, 3) != 0);
      step();
      exp_st = {CNT_W'(m_clk), CNT_W'(m_instr), m_q.size() != 0, (m_mode == 0) && (m_q.size() > DEPTH - RET_W), m_ovf, m_mode == 2, m_code};
      got_st = {clock_count, instr_count, trc_vld, ret_stall, ovf, halt, halt_code};
      total++; if (got_st !== exp_st) $display("FAIL rand_status c=%0d: got %h want %h", c, got_st, exp_st); else passed++;
      if (m_q.size() != 0) begin
        total++;
        if ({trc_pc, trc_wr_en, trc_wr_idx, trc_wr_data} !== {m_q[0].pc, m_q[0].wr_en, m_q[0].idx, m_q[0].data})
          $display("FAIL rand_head c=%0d: got pc=%h en=%b idx=%0d data=%h want pc=%h en=%b idx=%0d data=%h", c, trc_pc, trc_wr_en, trc_wr_idx, trc_wr_data, m_q[0].pc, m_q[0].wr_en, m_q[0].idx, m_q[0].data);
        else passed++;
      end
    end
    idle_inputs();
    total++; if ({clock_count, instr_count} !== {8'hFF, 8'hFF}) $display("FAIL saturate: got clk=%0d instr=%0d want 255/255", clock_count, instr_count); else passed++;
  endtask

  initial begin
    test_reset();
    test_dual_retire();
    test_single_lane();
    test_overflow();
    test_full_pop_push();
    test_halt();
    test_reset_in_drain();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
